updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down counter with programmable modulus, synchronous load, wrap or saturate mode and a terminal-count strobe. It is the generalised successor of the fixed 8-bit down counter. It serves as the common timing and event counter for the blocks that follow, including timers, baud dividers and frame counters. Behaviour is fully synchronous to one clock.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- RESET_VAL, 0, value of `count` after reset (WIDTH bits)
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- enable  input  1  count one step on this edge when 1
- up_down  input  1  direction: 1 = up, 0 = down
- load  input  1  load `load_val` on this edge
- load_val  input  WIDTH  value to load
- max_val  input  WIDTH  inclusive upper bound; count range is 0..max_val
- count  output  WIDTH  registered counter value
- tc  output  1  registered terminal-count strobe
- zero  output  1  combinational, `count == 0`

## Operation
- The edge priority, from highest to lowest, is: reset, load, enable, hold.
- **Reset (reset=0 at the edge):**
  - count ← RESET_VAL, tc ← 0.
  - load and enable are ignored.
- **Load:**
  - count ← min(load_val, max_val).
  - tc ← 0.
  - enable is ignored in that cycle.
- **Count up (enable=1, up_down=1):**
  - If count < max_val: count ← count+1, tc ← 0.
  - If count == max_val: count ← 0 (wrap) or stays max_val (saturate). tc ← 1.
- **Count down (enable=1, up_down=0):**
  - If count > 0: count ← count−1, tc ← 0.
  - If count == 0: count ← max_val (wrap) or stays 0 (saturate). tc ← 1.
- **Out-of-range (count > max_val, e.g. max_val lowered at runtime) with enable=1:**
  - Wrap mode, up: count ← 0.
  - Wrap mode, down: count ← max_val.
  - Saturate mode, either direction: count ← max_val.
  - tc ← 1 in all of these cases.
- **Hold (enable=0, load=0):** count is unchanged, tc ← 0.
- max_val = 0 is legal:
  - count stays 0 on every enabled step.
  - tc = 1 on every enabled step, in both modes.
- All arithmetic is unsigned and WIDTH bits wide; no carry leaves the block.
- max_val = 2^WIDTH−1 gives natural binary roll-over.
- There is no FSM. State is the count register plus the tc register.

## Timing
- Step latency: count updates on the same edge that samples enable. The new value is visible one cycle after enable is asserted.
- tc is registered and coincides with the cycle in which count shows the wrapped or held value. It is high for exactly one cycle per boundary step.
- In saturate mode with enable held at a boundary, tc stays high for every held cycle.
- zero follows count combinationally, with no added latency.
- Direction changes take effect on the next enabled edge. There are no dead cycles.
- Reset mid-count: the next edge gives count = RESET_VAL and tc = 0, regardless of other inputs. Counting resumes on the first edge where reset=1 and enable=1.
- Load and enable in the same cycle: load wins, tc = 0.
- Inputs are sampled only at the rising edge. No combinational input-to-output path exists except count→zero.

## Structure
- Shared package `counter_pkg`:
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - MODE_WRAP = 0, MODE_SAT = 1.
  - Reused by later timer and divider blocks.
- One combinational sub-module `counter_next`, parametrised by WIDTH and SATURATE:
  - Inputs: count, max_val, up_down.
  - Outputs: next value and boundary flag.
- The top level holds only the priority mux and the count/tc registers.

## Test plan
1. **Reset.** WIDTH=8, RESET_VAL=5; hold reset=0 for 2 cycles with enable=1. Expect count=5, tc=0, zero=0. Release reset; the first enabled up edge gives count=6.
2. **Wrap up.** max_val=9, SATURATE=0; load 7, then up ×4. Expect count 8, 9, 0, 1. tc=1 only in the cycle count=0.
3. **Down and reverse.** max_val=9; down from 1 twice. Expect count 0 (zero=1), then 9 with tc=1. Switch to up_down=1; the next step gives count=0 with tc=1.
4. **Saturate.** SATURATE=1, max_val=9; up from 8 ×3. Expect count 9, 9, 9, with tc=0, 1, 1.
5. **Load clamp and priority.** max_val=9; load=1 with load_val=200 and enable=1. Expect count=9, tc=0. Then assert reset=0 together with load=1. Expect count=RESET_VAL.
6. **Runtime max_val change.** count=50, max_val changed to 20, enable up. Expect count=0 (wrap) or 20 (saturate), tc=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared counter constants: direction encodings and boundary-mode selectors.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package counter_pkg;

    // Direction encoding for up_down.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Boundary behaviour: wrap around or hold at the limit.
    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for the up/down modulus counter.
// Latency: none (wires only).
// Backpressure: none; the counter accepts a command every cycle.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             zero;

    modport master (
        output enable, up_down, load, load_val, max_val,
        input  count, tc, zero
    );

    modport slave (
        input  enable, up_down, load, load_val, max_val,
        output count, tc, zero
    );
endinterface

// File: rtl/counter_next.sv
// Next-step value and boundary flag for one enabled count step.
// Latency: purely combinational.
// Backpressure: none.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_val,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary
);

    // Out-of-range counts (max_val lowered under us) are treated as a boundary
    // step in both directions so the counter re-enters 0..max_val immediately.
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        case (up_down)
            DIR_UP: begin
                if (count < max_val) begin
                    next_count = count + WIDTH'(1);
                end else begin
                    boundary   = 1'b1;
                    next_count = (SATURATE == MODE_WRAP) ? '0 : max_val;
                end
            end
            DIR_DOWN: begin
                if (count > max_val) begin
                    boundary   = 1'b1;
                    next_count = max_val;
                end else if (count == '0) begin
                    boundary   = 1'b1;
                    next_count = (SATURATE == MODE_WRAP) ? max_val : '0;
                end else begin
                    next_count = count - WIDTH'(1);
                end
            end
            default: begin
                next_count = count;
            end
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..max_val with load, wrap/saturate and terminal-count strobe.
// Latency: count and tc update on the sampling edge; zero follows count combinationally.
// Backpressure: none; every edge is a command (reset > load > enable > hold).
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = MODE_WRAP
) (
    input logic                clk,
    input logic                reset,
    updown_mod_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic [WIDTH-1:0] step_val;
    logic             step_bnd;
    logic [WIDTH-1:0] load_clamped;

    counter_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .max_val    (bus.max_val),
        .up_down    (bus.up_down),
        .next_count (step_val),
        .boundary   (step_bnd)
    );

    // Loaded values never land outside the programmed range.
    assign load_clamped = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;

    // Priority mux and state registers: reset, then load, then a count step, else hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamped;
            tc_q    <= 1'b0;
        end else if (bus.enable) begin
            count_q <= step_val;
            tc_q    <= step_bnd;
        end else begin
            tc_q    <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: one wrap-mode and one saturate-mode counter driven in lockstep.
// Expected results are queued when each command is driven and checked after its edge.
module tb_updown_mod_counter;

    localparam int W   = 8;
    localparam int RST = 5;

    logic clk;
    logic reset;

    updown_mod_counter_if #(.WIDTH(W)) bus_w ();
    updown_mod_counter_if #(.WIDTH(W)) bus_s ();

    updown_mod_counter #(.WIDTH(W), .RESET_VAL(8'd5), .SATURATE(1'b0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w.slave)
    );

    updown_mod_counter #(.WIDTH(W), .RESET_VAL(8'd5), .SATURATE(1'b1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int tc;
    } exp_t;

    exp_t q_wrap[$];
    exp_t q_sat[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per mode: index 0 = wrap, 1 = saturate.
    int m_cnt[2];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour for one edge, written from the operating rules.
    function automatic exp_t model(input int mode, input bit rst, input bit en,
                                   input bit ud, input bit ld, input int lv, input int mx);
        exp_t r;
        int   c;
        c    = m_cnt[mode];
        r.tc = 0;
        if (!rst) begin
            c = RST;
        end else if (ld) begin
            c = (lv > mx) ? mx : lv;
        end else if (en) begin
            if (c > mx) begin
                r.tc = 1;
                c    = (mode == 1 || !ud) ? mx : 0;
            end else if (ud) begin
                r.tc = (c == mx) ? 1 : 0;
                if (mode == 1) c = (c == mx) ? mx : c + 1;
                else           c = (c + 1) % (mx + 1);
            end else begin
                r.tc = (c == 0) ? 1 : 0;
                if (c == 0) c = (mode == 1) ? 0 : mx;
                else        c = c - 1;
            end
        end
        m_cnt[mode] = c;
        r.cnt       = c;
        return r;
    endfunction

    task automatic drive(input string tag, input bit rst, input bit en, input bit ud,
                         input bit ld, input int lv, input int mx);
        exp_t e;
        reset          = rst;
        bus_w.enable   = en;   bus_s.enable   = en;
        bus_w.up_down  = ud;   bus_s.up_down  = ud;
        bus_w.load     = ld;   bus_s.load     = ld;
        bus_w.load_val = W'(lv); bus_s.load_val = W'(lv);
        bus_w.max_val  = W'(mx); bus_s.max_val  = W'(mx);
        q_wrap.push_back(model(0, rst, en, ud, ld, lv, mx));
        q_sat.push_back(model(1, rst, en, ud, ld, lv, mx));
        @(posedge clk);
        #1;
        e = q_wrap.pop_front();
        check({tag, "/w.count"}, int'(bus_w.count), e.cnt);
        check({tag, "/w.tc"},    int'(bus_w.tc),    e.tc);
        check({tag, "/w.zero"},  int'(bus_w.zero),  (e.cnt == 0) ? 1 : 0);
        e = q_sat.pop_front();
        check({tag, "/s.count"}, int'(bus_s.count), e.cnt);
        check({tag, "/s.tc"},    int'(bus_s.tc),    e.tc);
        check({tag, "/s.zero"},  int'(bus_s.zero),  (e.cnt == 0) ? 1 : 0);
    endtask

    initial begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;

        // Reset held two cycles with enable high, then first enabled up edge.
        drive("rst0", 0, 1, 1, 0, 0, 9);
        drive("rst1", 0, 1, 1, 0, 0, 9);
        check("rst_const", int'(bus_w.count), 5);
        drive("rst_rel", 1, 1, 1, 0, 0, 9);
        check("rst_rel_const", int'(bus_w.count), 6);

        // Load 7 then up x4 (wrap: 8,9,0,1).
        drive("ld7", 1, 0, 1, 1, 7, 9);
        for (int i = 0; i < 4; i++) drive("up", 1, 1, 1, 0, 0, 9);
        check("wrap_const", int'(bus_w.count), 1);

        // Down from 1 twice, then reverse.
        drive("ld1", 1, 0, 0, 1, 1, 9);
        drive("dn", 1, 1, 0, 0, 0, 9);
        drive("dn", 1, 1, 0, 0, 0, 9);
        check("dn_wrap_const", int'(bus_w.count), 9);
        drive("rev", 1, 1, 1, 0, 0, 9);

        // Saturate from 8 up x3.
        drive("ld8", 1, 0, 1, 1, 8, 9);
        for (int i = 0; i < 3; i++) drive("sat", 1, 1, 1, 0, 0, 9);
        check("sat_const", int'(bus_s.count), 9);

        // Hold cycle drops tc.
        drive("hold", 1, 0, 1, 0, 0, 9);

        // Load clamp wins over enable; reset wins over load.
        drive("clamp", 1, 1, 1, 1, 200, 9);
        check("clamp_const", int'(bus_w.count), 9);
        drive("rst_ld", 0, 1, 1, 1, 3, 9);

        // Runtime max_val reduction, both directions.
        drive("ld50", 1, 0, 1, 1, 50, 255);
        drive("oor_up", 1, 1, 1, 0, 0, 20);
        check("oor_up_const", int'(bus_s.count), 20);
        drive("ld50b", 1, 0, 1, 1, 50, 255);
        drive("oor_dn", 1, 1, 0, 0, 0, 20);

        // max_val = 0: always 0, tc every enabled step.
        drive("ld0", 1, 0, 1, 1, 4, 0);
        for (int i = 0; i < 4; i++) drive("mx0", 1, 1, i[0], 0, 0, 0);

        // Full range natural roll-over.
        drive("ld255", 1, 0, 1, 1, 255, 255);
        drive("roll_up", 1, 1, 1, 0, 0, 255);
        drive("roll_dn", 1, 1, 0, 0, 0, 255);

        // Random mix, including runtime max_val changes.
        for (int i = 0; i < 300; i++) begin
            drive("rnd", ($urandom_range(0, 31) != 0), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 20), (i % 50 < 45) ? $urandom_range(0, 15) : 255);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
